// File: rtl/parity_frame_serializer_pkg.sv
// Shared definitions for the parity frame serializer.
// Contents:
//   - state encodings and state_t typedef (IDLE, SHIFT, PAR, GAP)
//   - cnt_width(): bit counter width for a given word width
// The PAR state is only entered when PARITY_FRAME_BIT_EN is defined.
package parity_frame_serializer_pkg;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_SHIFT = 2'd1;
    localparam logic [1:0] ENC_PAR   = 2'd2;
    localparam logic [1:0] ENC_GAP   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ENC_IDLE,
        ST_SHIFT = ENC_SHIFT,
        ST_PAR   = ENC_PAR,
        ST_GAP   = ENC_GAP
    } state_t;

    // Wide enough to hold DATA_W itself, so the counter cannot wrap
    // inside a frame.
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w + 32'sd1);
    endfunction

endpackage

// File: rtl/parity_frame_shift_reg.sv
// Load/shift register for the parity frame serializer.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   load              capture data_in (and its parity)
//   shift             shift right by one, LSB leaves first
//   data_in [DATA_W]  parallel word
//   lsb               current bit to place on the serial line
//   parity            XOR of the captured word (only with PARITY_FRAME_BIT_EN)
module parity_frame_shift_reg
    import parity_frame_serializer_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] data_in,
    output logic              lsb
`ifdef PARITY_FRAME_BIT_EN
    ,
    output logic              parity
`endif
);

    logic [DATA_W-1:0] sh_r;

    // Word storage: load has priority over shift.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_r <= {DATA_W{1'b0}};
        end else if (load) begin
            sh_r <= data_in;
        end else if (shift) begin
            sh_r <= sh_r >> 1'b1;
        end else begin
            sh_r <= sh_r;
        end
    end

    assign lsb = sh_r[0];

`ifdef PARITY_FRAME_BIT_EN
    logic par_r;

    // Parity of the captured word, fixed for the whole frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_r <= 1'b0;
        end else if (load) begin
            par_r <= ^data_in;
        end else begin
            par_r <= par_r;
        end
    end

    assign parity = par_r;
`endif

endmodule

// File: rtl/parity_frame_serializer.sv
// Parallel-to-serial frame generator feeding the serial parity checker.
// A word accepted on in_valid&in_ready at edge N is sent LSB-first in
// cycles N+1..N+L, followed by GAP_CYCLES idle cycles.
// Optional feature: PARITY_FRAME_BIT_EN appends an even-parity bit
// (frame length DATA_W+1); undefined gives frame length DATA_W.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   in_valid, in_data   word offer from the source
//   in_ready            word can be taken this cycle
//   serial_out          serial bit, 0 when bit_valid is 0
//   bit_valid           serial_out carries a frame bit
//   frame_start         first bit of a frame
//   frame_end           last bit of a frame (parity bit if enabled)
//   busy                frame or inter-frame gap in progress
// All outputs are decoded from registered state only.
module parity_frame_serializer
    import parity_frame_serializer_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              serial_out,
    output logic              bit_valid,
    output logic              frame_start,
    output logic              frame_end,
    output logic              busy
);

    localparam int            CW          = cnt_width(DATA_W);
    localparam logic [CW-1:0] LAST_BIT    = CW'(DATA_W - 1);
    localparam logic [3:0]    GAP_LAST    = 4'(GAP_CYCLES - 1);
    localparam state_t        AFTER_FRAME = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] bit_cnt_r;
    logic [3:0]    gap_cnt_r;
    logic          ready_en_r;
    logic          load_s;
    logic          shift_s;
    logic          lsb_s;
`ifdef PARITY_FRAME_BIT_EN
    logic          parity_s;
`endif

    parity_frame_shift_reg #(
        .DATA_W (DATA_W)
    ) u_shift_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load_s),
        .shift   (shift_s),
        .data_in (in_data),
        .lsb     (lsb_s)
`ifdef PARITY_FRAME_BIT_EN
        ,
        .parity  (parity_s)
`endif
    );

    // State, counters and the post-reset ready enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= {CW{1'b0}};
            gap_cnt_r  <= 4'd0;
            ready_en_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            // in_ready may only rise one edge after reset release
            ready_en_r <= 1'b1;
            if (state_r == ST_SHIFT) begin
                bit_cnt_r <= bit_cnt_r + CW'(1'b1);
            end else begin
                bit_cnt_r <= {CW{1'b0}};
            end
            if (state_r == ST_GAP) begin
                gap_cnt_r <= gap_cnt_r + 4'd1;
            end else begin
                gap_cnt_r <= 4'd0;
            end
        end
    end

    // Next-state and shift-register control.
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        shift_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && ready_en_r) begin
                    load_s  = 1'b1;
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shift_s = 1'b1;
                if (bit_cnt_r == LAST_BIT) begin
`ifdef PARITY_FRAME_BIT_EN
                    state_s = ST_PAR;
`else
                    state_s = AFTER_FRAME;
`endif
                end else begin
                    state_s = ST_SHIFT;
                end
            end
`ifdef PARITY_FRAME_BIT_EN
            ST_PAR: begin
                state_s = AFTER_FRAME;
            end
`endif
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_GAP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state.
    always_comb begin
        in_ready    = (state_r == ST_IDLE) && ready_en_r;
        busy        = (state_r != ST_IDLE);
        frame_start = (state_r == ST_SHIFT) && (bit_cnt_r == {CW{1'b0}});
`ifdef PARITY_FRAME_BIT_EN
        bit_valid   = (state_r == ST_SHIFT) || (state_r == ST_PAR);
        frame_end   = (state_r == ST_PAR);
        if (state_r == ST_SHIFT) begin
            serial_out = lsb_s;
        end else if (state_r == ST_PAR) begin
            serial_out = parity_s;
        end else begin
            serial_out = 1'b0;
        end
`else
        bit_valid   = (state_r == ST_SHIFT);
        frame_end   = (state_r == ST_SHIFT) && (bit_cnt_r == LAST_BIT);
        if (state_r == ST_SHIFT) begin
            serial_out = lsb_s;
        end else begin
            serial_out = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_parity_frame_serializer.sv
// Self-checking bench for parity_frame_serializer: an 8-bit/gap-1 instance
// and a 1-bit/gap-0 instance, checked cycle by cycle against frame bits
// derived from the accepted words.
module tb_parity_frame_serializer;

`ifdef PARITY_FRAME_BIT_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int L8  = 8 + PB;
    localparam int G8  = 1;
    localparam int L1  = 1 + PB;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid, in_ready, serial_out, bit_valid, frame_start, frame_end, busy;
    logic [7:0] in_data;
    logic       v1, ready1, ser1, bv1, fs1, fe1, busy1;
    logic [0:0] d1;

    int n_vec = 0;
    int n_bad = 0;

    parity_frame_serializer #(.DATA_W(8), .GAP_CYCLES(1)) dut8 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .serial_out(serial_out), .bit_valid(bit_valid),
        .frame_start(frame_start), .frame_end(frame_end), .busy(busy)
    );

    parity_frame_serializer #(.DATA_W(1), .GAP_CYCLES(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(v1), .in_data(d1),
        .in_ready(ready1), .serial_out(ser1), .bit_valid(bv1),
        .frame_start(fs1), .frame_end(fe1), .busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit k of a frame: data bits LSB-first, then the even-parity bit.
    function automatic logic exp_bit(input logic [31:0] w, input int dw, input int k);
        if (k < dw) return w[k];
        return 1'($countones(w) % 2);
    endfunction

    // Send one word on dut8 and check the whole frame and gap.
    task automatic run_frame(input logic [7:0] word, input bit pulse,
                             input bit chain, input logic [7:0] nxt);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = word;
        chk("ready_idle", in_ready, 32'd1);
        tick();
        if (chain) in_data = nxt;
        else       in_valid = 1'b0;
        for (int k = 0; k < L8; k++) begin
            chk("bit_valid",   bit_valid, 32'd1);
            chk("serial_bit",  serial_out, exp_bit({24'd0, word}, 8, k));
            chk("frame_start", frame_start, (k == 0) ? 32'd1 : 32'd0);
            chk("frame_end",   frame_end, (k == L8 - 1) ? 32'd1 : 32'd0);
            chk("ready_busy",  {in_ready, busy}, 32'd1);
            acc = acc ^ serial_out;
            if (pulse && k == 2) begin
                in_valid = 1'b1;
                in_data  = ~word;
            end
            if (pulse && k == 3) begin
                in_valid = 1'b0;
                in_data  = word;
            end
            tick();
        end
        for (int g = 0; g < G8; g++) begin
            chk("gap_line",       {bit_valid, serial_out, frame_start, frame_end}, 32'd0);
            chk("gap_ready_busy", {in_ready, busy}, 32'd1);
            tick();
        end
        chk("ready_after", {in_ready, busy, bit_valid}, 32'd4);
`ifdef PARITY_FRAME_BIT_EN
        chk("checker_zero", acc, 32'd0);
`else
        chk("frame_ones", acc, 32'($countones(word) % 2));
`endif
    endtask

    initial begin
        logic [7:0] w;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        v1       = 1'b0;
        d1       = 1'b0;
        #1;
        chk("reset_outs", {in_ready, serial_out, bit_valid, frame_start, frame_end, busy}, 32'd0);
        chk("reset_outs1", {ready1, ser1, bv1, fs1, fe1, busy1}, 32'd0);
        tick();
        chk("reset_hold_ready", in_ready, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("release_no_edge", in_ready, 32'd0);
        tick();
        chk("first_edge_ready", {in_ready, ready1}, 32'd3);

        // Directed words
        run_frame(8'hA5, 1'b0, 1'b0, 8'h00);
        run_frame(8'h07, 1'b0, 1'b0, 8'h00);
        run_frame(8'h03, 1'b0, 1'b0, 8'h00);

        // Back-to-back with in_valid held high
        run_frame(8'h01, 1'b0, 1'b1, 8'h80);
        run_frame(8'h80, 1'b0, 1'b0, 8'h00);

        // in_valid pulse mid-frame must be ignored
        run_frame(8'h3C, 1'b1, 1'b0, 8'h00);
        tick();
        chk("no_capture", {bit_valid, busy}, 32'd0);

        // Random words
        for (int i = 0; i < 16; i++) begin
            w = 8'($urandom_range(0, 255));
            run_frame(w, 1'b0, (i % 4) == 1, 8'($urandom_range(0, 255)));
            if ((i % 4) == 1) begin
                w = in_data;
                run_frame(w, 1'b0, 1'b0, 8'h00);
            end
        end

        // Reset asserted at bit 3
        in_valid = 1'b1;
        in_data  = 8'hF6;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("bit3_before_reset", {bit_valid, serial_out}, 32'd2);
        reset_n = 1'b0;
        #1;
        chk("async_reset_outs", {in_ready, serial_out, bit_valid, frame_start, frame_end, busy}, 32'd0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("post_release_ready", in_ready, 32'd0);
        tick();
        chk("post_release_edge", {in_ready, busy, bit_valid, serial_out}, 32'd8);
        tick();
        chk("no_stale_bits", {busy, bit_valid, serial_out}, 32'd0);
        run_frame(8'h5A, 1'b0, 1'b0, 8'h00);

        // 1-bit instance, no gap, alternating 1,0 with in_valid held high
        v1 = 1'b1;
        d1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = {7'd0, d1};
            chk("w1_ready", ready1, 32'd1);
            tick();
            d1 = (i % 2 == 0) ? 1'b0 : 1'b1;
            for (int k = 0; k < L1; k++) begin
                chk("w1_valid", {bv1, busy1, ready1}, 32'd6);
                chk("w1_bit",   ser1, exp_bit({24'd0, w}, 1, k));
                chk("w1_start", fs1, (k == 0) ? 32'd1 : 32'd0);
                chk("w1_end",   fe1, (k == L1 - 1) ? 32'd1 : 32'd0);
                tick();
            end
        end
        v1 = 1'b0;
        chk("w1_idle", {ready1, bv1, busy1}, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
